// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. buffered long-latency results,
// with bounded starvation and a pending-write scoreboard for decode hazard stalls.
module rf_write_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_pipe_we,
  input  logic [4:0]      i_pipe_rd,
  input  logic [XLEN-1:0] i_pipe_din,
  output logic            o_pipe_hold,
  input  logic            i_ll_valid,
  output logic            o_ll_ready,
  input  logic [4:0]      i_ll_rd,
  input  logic [XLEN-1:0] i_ll_din,
  input  logic            i_ll_issue,
  input  logic [4:0]      i_ll_issue_rd,
  input  logic            i_id_valid,
  input  logic [4:0]      i_id_rs1,
  input  logic [4:0]      i_id_rs2,
  input  logic [4:0]      i_id_rd,
  output logic            o_id_stall,
  output logic            o_wb_reg_write,
  output logic [4:0]      o_wb_rd,
  output logic [XLEN-1:0] o_rd_din
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ST_W  = $clog2(STARVE_MAX + 1);

  logic [4:0]      fifo_rd  [DEPTH];
  logic [XLEN-1:0] fifo_din [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [ST_W-1:0]  starve, starve_nxt;
  logic [31:0]      pending, pending_nxt;

  logic       pipe_req, fifo_req, pipe_grant, fifo_grant, push;
  logic [4:0] head_rd;

  // Arbitration: pipeline has priority until the FIFO has waited STARVE_MAX cycles.
  always_comb begin
    o_ll_ready  = (count < CNT_W'(DEPTH));
    push        = i_ll_valid && o_ll_ready;
    pipe_req    = i_pipe_we && (i_pipe_rd != 5'd0);
    fifo_req    = (count != '0);
    pipe_grant  = pipe_req && !(fifo_req && (starve == ST_W'(STARVE_MAX)));
    fifo_grant  = fifo_req && !pipe_grant;
    o_pipe_hold = pipe_req && fifo_grant;
    head_rd     = fifo_rd[rd_ptr];
  end

  // Scoreboard and starvation next-state; a same-cycle issue overrides the clear.
  always_comb begin
    pending_nxt = pending;
    starve_nxt  = starve;
    if (fifo_grant) pending_nxt[head_rd] = 1'b0;
    if (i_ll_issue && (i_ll_issue_rd != 5'd0)) pending_nxt[i_ll_issue_rd] = 1'b1;
    if (!fifo_req || fifo_grant) begin
      starve_nxt = '0;
    end else if (pipe_grant && (starve != ST_W'(STARVE_MAX))) begin
      starve_nxt = starve + ST_W'(1);
    end
  end

  always_comb begin
    o_id_stall = i_id_valid &&
                 (((i_id_rs1 != 5'd0) && pending[i_id_rs1]) ||
                  ((i_id_rs2 != 5'd0) && pending[i_id_rs2]) ||
                  ((i_id_rd  != 5'd0) && pending[i_id_rd]));
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_rd[wr_ptr]  <= i_ll_rd;
      fifo_din[wr_ptr] <= i_ll_din;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      starve  <= '0;
      pending <= '0;
    end else begin
      if (push)       wr_ptr <= wr_ptr + PTR_W'(1);
      if (fifo_grant) rd_ptr <= rd_ptr + PTR_W'(1);
      count   <= count + CNT_W'(push) - CNT_W'(fifo_grant);
      starve  <= starve_nxt;
      pending <= pending_nxt;
    end
  end

  // Write port; an x0 FIFO head is consumed without touching the port.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wb_reg_write <= 1'b0;
      o_wb_rd        <= '0;
      o_rd_din       <= '0;
    end else if (pipe_grant) begin
      o_wb_reg_write <= 1'b1;
      o_wb_rd        <= i_pipe_rd;
      o_rd_din       <= i_pipe_din;
    end else if (fifo_grant && (head_rd != 5'd0)) begin
      o_wb_reg_write <= 1'b1;
      o_wb_rd        <= head_rd;
      o_rd_din       <= fifo_din[rd_ptr];
    end else begin
      o_wb_reg_write <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed vector table, reset corner, and random traffic
// against a queue-based reference model.
module tb_rf_write_arbiter;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned DEPTH      = 2;
  localparam int unsigned STARVE_MAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            pipe_we, pipe_hold, ll_valid, ll_ready, ll_issue, id_valid, id_stall, wb_we;
  logic [4:0]      pipe_rd, ll_rd, ll_issue_rd, id_rs1, id_rs2, id_rd, wb_rd;
  logic [XLEN-1:0] pipe_din, ll_din, rd_din;

  rf_write_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_pipe_we(pipe_we), .i_pipe_rd(pipe_rd), .i_pipe_din(pipe_din), .o_pipe_hold(pipe_hold),
    .i_ll_valid(ll_valid), .o_ll_ready(ll_ready), .i_ll_rd(ll_rd), .i_ll_din(ll_din),
    .i_ll_issue(ll_issue), .i_ll_issue_rd(ll_issue_rd),
    .i_id_valid(id_valid), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_rd(id_rd),
    .o_id_stall(id_stall),
    .o_wb_reg_write(wb_we), .o_wb_rd(wb_rd), .o_rd_din(rd_din)
  );

  typedef struct {
    logic pwe; logic [4:0] prd; logic [31:0] pdin;
    logic lv;  logic [4:0] lrd; logic [31:0] ldin;
    logic iss; logic [4:0] isrd;
    logic idv; logic [4:0] rs1, rs2, idrd;
    logic e_ready, e_hold, e_stall, e_we; logic [4:0] e_rd; logic [31:0] e_din;
  } vec_t;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic pwe, input logic [4:0] prd, input logic [31:0] pdin,
                               input logic lv, input logic [4:0] lrd, input logic [31:0] ldin,
                               input logic iss, input logic [4:0] isrd,
                               input logic idv, input logic [4:0] rs1,
                               input logic e_ready, input logic e_hold, input logic e_stall,
                               input logic e_we, input logic [4:0] e_rd, input logic [31:0] e_din);
    vec_t v;
    v.pwe = pwe; v.prd = prd; v.pdin = pdin; v.lv = lv; v.lrd = lrd; v.ldin = ldin;
    v.iss = iss; v.isrd = isrd; v.idv = idv; v.rs1 = rs1; v.rs2 = 5'd0; v.idrd = 5'd0;
    v.e_ready = e_ready; v.e_hold = e_hold; v.e_stall = e_stall;
    v.e_we = e_we; v.e_rd = e_rd; v.e_din = e_din;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    pipe_we = v.pwe; pipe_rd = v.prd; pipe_din = v.pdin;
    ll_valid = v.lv; ll_rd = v.lrd; ll_din = v.ldin;
    ll_issue = v.iss; ll_issue_rd = v.isrd;
    id_valid = v.idv; id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.idrd;
  endtask

  // Called at a falling edge: check combinational outputs, then the registered port after the edge.
  task automatic run_vec(input vec_t v, input string tag);
    drive(v);
    #1;
    chk({tag, ".ll_ready"},  32'(ll_ready),  32'(v.e_ready));
    chk({tag, ".pipe_hold"}, 32'(pipe_hold), 32'(v.e_hold));
    chk({tag, ".id_stall"},  32'(id_stall),  32'(v.e_stall));
    @(posedge clk);
    #1;
    chk({tag, ".wb_we"}, 32'(wb_we), 32'(v.e_we));
    chk({tag, ".wb_rd"}, 32'(wb_rd), 32'(v.e_rd));
    chk({tag, ".wb_din"}, rd_din, v.e_din);
    @(negedge clk);
  endtask

  // Reference model: results as a queue, scoreboard as a bit array.
  logic [4:0]  mq_rd[$];
  logic [31:0] mq_din[$];
  int          m_starve;
  bit          m_pend[32];
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_din;

  task automatic model_reset();
    mq_rd.delete(); mq_din.delete();
    m_starve = 0; m_we = 1'b0; m_rd = 5'd0; m_din = 32'd0;
    foreach (m_pend[i]) m_pend[i] = 1'b0;
  endtask

  task automatic model_step(inout vec_t v);
    int          n;
    bit          p, f, pw, fw, push;
    logic [4:0]  hr;
    logic [31:0] hd;
    n  = mq_rd.size();
    p  = v.pwe && (v.prd != 5'd0);
    f  = (n != 0);
    pw = p && !(f && (m_starve >= int'(STARVE_MAX)));
    fw = f && !pw;
    push = v.lv && (n < int'(DEPTH));
    v.e_ready = (n < int'(DEPTH));
    v.e_hold  = p && fw;
    v.e_stall = v.idv && (((v.rs1 != 0) && m_pend[v.rs1]) || ((v.rs2 != 0) && m_pend[v.rs2]) ||
                          ((v.idrd != 0) && m_pend[v.idrd]));
    if (pw) begin
      m_we = 1'b1; m_rd = v.prd; m_din = v.pdin;
    end else if (fw) begin
      hr = mq_rd.pop_front();
      hd = mq_din.pop_front();
      m_pend[hr] = 1'b0;
      if (hr != 5'd0) begin
        m_we = 1'b1; m_rd = hr; m_din = hd;
      end else begin
        m_we = 1'b0;
      end
    end else begin
      m_we = 1'b0;
    end
    if (v.iss && (v.isrd != 5'd0)) m_pend[v.isrd] = 1'b1;
    if (push) begin
      mq_rd.push_back(v.lrd);
      mq_din.push_back(v.ldin);
    end
    if (!f || fw) m_starve = 0;
    else if (m_starve < int'(STARVE_MAX)) m_starve++;
    v.e_we = m_we; v.e_rd = m_rd; v.e_din = m_din;
  endtask

  vec_t tbl[26];
  vec_t idle;

  initial begin
    vec_t r, prev;
    bit   hold_prev;

    // pwe prd pdin | lv lrd ldin | iss isrd | idv rs1 | ready hold stall | we rd din
    tbl[0]  = mkv(1, 5,  32'h1234, 0, 0,  0,         0, 0,  0, 0,  1, 0, 0,  1, 5,  32'h1234);
    tbl[1]  = mkv(0, 0,  0,        0, 0,  0,         1, 7,  0, 0,  1, 0, 0,  0, 5,  32'h1234);
    tbl[2]  = mkv(0, 0,  0,        0, 0,  0,         0, 0,  1, 7,  1, 0, 1,  0, 5,  32'h1234);
    tbl[3]  = mkv(0, 0,  0,        1, 7,  32'hDEAD,  0, 0,  1, 7,  1, 0, 1,  0, 5,  32'h1234);
    tbl[4]  = mkv(0, 0,  0,        0, 0,  0,         0, 0,  1, 7,  1, 0, 1,  1, 7,  32'hDEAD);
    tbl[5]  = mkv(0, 0,  0,        0, 0,  0,         0, 0,  1, 7,  1, 0, 0,  0, 7,  32'hDEAD);
    tbl[6]  = mkv(1, 1,  32'h11,   1, 9,  32'h99,    0, 0,  0, 0,  1, 0, 0,  1, 1,  32'h11);
    tbl[7]  = mkv(1, 2,  32'h22,   0, 0,  0,         0, 0,  0, 0,  1, 0, 0,  1, 2,  32'h22);
    tbl[8]  = mkv(1, 3,  32'h33,   0, 0,  0,         0, 0,  0, 0,  1, 0, 0,  1, 3,  32'h33);
    tbl[9]  = mkv(1, 4,  32'h44,   0, 0,  0,         0, 0,  0, 0,  1, 0, 0,  1, 4,  32'h44);
    tbl[10] = mkv(1, 6,  32'h66,   0, 0,  0,         0, 0,  0, 0,  1, 0, 0,  1, 6,  32'h66);
    tbl[11] = mkv(1, 8,  32'h88,   0, 0,  0,         0, 0,  0, 0,  1, 1, 0,  1, 9,  32'h99);
    tbl[12] = mkv(1, 8,  32'h88,   0, 0,  0,         0, 0,  0, 0,  1, 0, 0,  1, 8,  32'h88);
    tbl[13] = mkv(1, 0,  32'h5,    1, 0,  32'hBAD,   0, 0,  0, 0,  1, 0, 0,  0, 8,  32'h88);
    tbl[14] = mkv(1, 0,  32'h5,    0, 0,  0,         0, 0,  0, 0,  1, 0, 0,  0, 8,  32'h88);
    tbl[15] = mkv(0, 0,  0,        0, 0,  0,         0, 0,  0, 0,  1, 0, 0,  0, 8,  32'h88);
    tbl[16] = mkv(1, 10, 32'hA0,   1, 11, 32'hB1,    0, 0,  0, 0,  1, 0, 0,  1, 10, 32'hA0);
    tbl[17] = mkv(1, 12, 32'hA2,   1, 13, 32'hB3,    0, 0,  0, 0,  1, 0, 0,  1, 12, 32'hA2);
    tbl[18] = mkv(1, 14, 32'hA4,   1, 15, 32'hB5,    0, 0,  0, 0,  0, 0, 0,  1, 14, 32'hA4);
    tbl[19] = mkv(1, 16, 32'hA6,   1, 15, 32'hB5,    0, 0,  0, 0,  0, 0, 0,  1, 16, 32'hA6);
    tbl[20] = mkv(1, 17, 32'hA7,   1, 15, 32'hB5,    0, 0,  0, 0,  0, 0, 0,  1, 17, 32'hA7);
    tbl[21] = mkv(1, 18, 32'hA8,   1, 15, 32'hB5,    0, 0,  0, 0,  0, 1, 0,  1, 11, 32'hB1);
    tbl[22] = mkv(1, 18, 32'hA8,   1, 15, 32'hB5,    0, 0,  0, 0,  1, 0, 0,  1, 18, 32'hA8);
    tbl[23] = mkv(0, 0,  0,        0, 0,  0,         0, 0,  0, 0,  0, 0, 0,  1, 13, 32'hB3);
    tbl[24] = mkv(0, 0,  0,        0, 0,  0,         0, 0,  0, 0,  1, 0, 0,  1, 15, 32'hB5);
    tbl[25] = mkv(0, 0,  0,        0, 0,  0,         0, 0,  0, 0,  1, 0, 0,  0, 15, 32'hB5);
    idle = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    rst_n = 1'b0;
    drive(idle);
    repeat (3) @(posedge clk);
    #1;
    chk("rst.wb_we", 32'(wb_we), 32'd0);
    chk("rst.wb_rd", 32'(wb_rd), 32'd0);
    chk("rst.wb_din", rd_din, 32'd0);
    chk("rst.ll_ready", 32'(ll_ready), 32'd1);
    chk("rst.pipe_hold", 32'(pipe_hold), 32'd0);
    chk("rst.id_stall", 32'(id_stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 26; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Reset while the FIFO is full and two registers are pending.
    r = mkv(1, 1, 32'h1, 1, 20, 32'h20, 1, 20, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(r); @(negedge clk);
    r = mkv(1, 2, 32'h2, 1, 21, 32'h21, 1, 21, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(r); @(negedge clk);
    r = mkv(1, 3, 32'h3, 0, 0, 0, 0, 0, 1, 20, 0, 0, 0, 0, 0, 0);
    r.rs2 = 5'd21;
    drive(r);
    #1;
    chk("pre_rst.ll_ready", 32'(ll_ready), 32'd0);
    chk("pre_rst.id_stall", 32'(id_stall), 32'd1);
    chk("pre_rst.wb_we", 32'(wb_we), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst.wb_we", 32'(wb_we), 32'd0);
    chk("async_rst.wb_rd", 32'(wb_rd), 32'd0);
    chk("async_rst.wb_din", rd_din, 32'd0);
    chk("async_rst.ll_ready", 32'(ll_ready), 32'd1);
    chk("async_rst.pipe_hold", 32'(pipe_hold), 32'd0);
    chk("async_rst.id_stall", 32'(id_stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Random traffic; a held pipeline write is re-presented unchanged.
    hold_prev = 1'b0;
    prev = idle;
    for (int i = 0; i < 1500; i++) begin
      r = idle;
      if (hold_prev) begin
        r.pwe = prev.pwe; r.prd = prev.prd; r.pdin = prev.pdin;
      end else begin
        r.pwe  = ($urandom_range(0, 9) < 8);
        r.prd  = 5'($urandom_range(0, 31));
        r.pdin = $urandom;
      end
      r.lv   = ($urandom_range(0, 2) == 0);
      r.lrd  = 5'($urandom_range(0, 31));
      r.ldin = $urandom;
      r.isrd = 5'($urandom_range(0, 31));
      r.iss  = ($urandom_range(0, 3) == 0) && !m_pend[r.isrd];
      r.idv  = $urandom_range(0, 1) == 1;
      r.rs1  = 5'($urandom_range(0, 31));
      r.rs2  = 5'($urandom_range(0, 31));
      r.idrd = 5'($urandom_range(0, 31));
      model_step(r);
      run_vec(r, $sformatf("rnd%0d", i));
      hold_prev = r.e_hold;
      prev = r;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
